demux_two_outs_reg: RTL and testbench

//  Registered 1-to-2 demultiplexer: the steering counterpart of the 2:1 data muxes in the SVD datapath.

---
 rtl/demux_two_outs_reg.sv | 85 ++++++++
 tb/tb_demux_two_outs_reg.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_two_outs_reg.sv
// Registered 1-to-2 demultiplexer with one-entry output slots and valid/ready handshakes.
// Each destination drains independently; per-destination accepted-word counters wrap freely.
module demux_two_outs_reg #(
  parameter int unsigned data_width = 256,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_sel,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [data_width-1:0] out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [data_width-1:0] out1_data,
  output logic [cnt_width-1:0]  cnt0,
  output logic [cnt_width-1:0]  cnt1
);

  logic                  valid0_q, valid0_d, valid1_q, valid1_d;
  logic [data_width-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [cnt_width-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                  free0, free1, acc0, acc1, dlv0, dlv1;

  // A full slot still counts as free when it drains this cycle, giving 1 word/cycle.
  always_comb begin
    free0    = !valid0_q || out0_ready;
    free1    = !valid1_q || out1_ready;
    in_ready = !rst && (in_sel ? free1 : free0);
    acc0     = in_valid && in_ready && !in_sel;
    acc1     = in_valid && in_ready && in_sel;
    dlv0     = valid0_q && out0_ready;
    dlv1     = valid1_q && out1_ready;
  end

  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    if (dlv0) valid0_d = 1'b0;
    if (dlv1) valid1_d = 1'b0;
    if (acc0) begin
      valid0_d = 1'b1;
      data0_d  = in_data;
      cnt0_d   = cnt0_q + cnt_width'(1);
    end
    if (acc1) begin
      valid1_d = 1'b1;
      data1_d  = in_data;
      cnt1_d   = cnt1_q + cnt_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign out0_valid = valid0_q;
  assign out1_valid = valid1_q;
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux_two_outs_reg.sv
// Bench for demux_two_outs_reg: directed scenarios plus randomized traffic against a
// queue-based model (one FIFO of undelivered words per destination).
module tb_demux_two_outs_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_sel;
  logic [DW-1:0] in_data;
  logic          out0_valid, out0_ready, out1_valid, out1_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic [CW-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  int            mcnt0, mcnt1;

  demux_two_outs_reg #(.data_width(DW), .cnt_width(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  // Expected in_ready: destination has nothing pending, or its pending word leaves now.
  function automatic logic model_in_ready();
    if (rst) return 1'b0;
    if (in_sel) return (mq1.size() == 0) || out1_ready;
    return (mq0.size() == 0) || out0_ready;
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    logic acc, d0, d1;
    acc = in_valid && model_in_ready();
    d0  = out0_ready && (mq0.size() != 0);
    d1  = out1_ready && (mq1.size() != 0);
    @(posedge clk);
    if (rst) begin
      mq0.delete();
      mq1.delete();
      mcnt0 = 0;
      mcnt1 = 0;
    end else begin
      if (d0) void'(mq0.pop_front());
      if (d1) void'(mq1.pop_front());
      if (acc) begin
        if (in_sel) begin
          mq1.push_back(in_data);
          mcnt1 = (mcnt1 + 1) % (1 << CW);
        end else begin
          mq0.push_back(in_data);
          mcnt0 = (mcnt0 + 1) % (1 << CW);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b/%b expected 0/0", out0_valid, out1_valid);
    end
    n_checks++;
    if (cnt0 !== '0 || cnt1 !== '0 || out0_data !== '0 || out1_data !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt_data: cnt %0d/%0d data %h/%h expected all 0",
               cnt0, cnt1, out0_data, out1_data);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0 during reset", in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_stream();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_sel   = ((i - 1) % 2) != 0;
      in_data  = DW'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick();
      n_checks++;
      if (in_sel ? (out1_valid !== 1'b1 || out1_data !== DW'(i))
                 : (out0_valid !== 1'b1 || out0_data !== DW'(i))) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: out0 %b/%0d out1 %b/%0d expected word %0d on out%0d",
                 i, out0_valid, out0_data, out1_valid, out1_data, i, in_sel);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (cnt0 !== 4'd4 || cnt1 !== 4'd4 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: cnt %0d/%0d valid %b/%b expected 4/4 0/0",
               cnt0, cnt1, out0_valid, out1_valid);
    end
  endtask

  task automatic test_stall();
    out0_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'h0000_00AA;
    tick();
    in_data = 32'h0000_00BB;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_in_ready: got %b expected 0", in_ready);
    end
    tick();
    n_checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hAA) begin
      n_fail++;
      $display("FAIL stall_hold: got %b/%h expected 1/aa", out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    n_checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hBB) begin
      n_fail++;
      $display("FAIL stall_release_data: got %b/%h expected 1/bb", out0_valid, out0_data);
    end
  endtask

  // out0 still holds BB with out0_ready low.
  task automatic test_independence();
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 32'h0000_00CC;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL indep_in_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hCC || out0_valid !== 1'b1 ||
        out0_data !== 32'hBB) begin
      n_fail++;
      $display("FAIL indep_out: out0 %b/%h out1 %b/%h expected 1/bb 1/cc",
               out0_valid, out0_data, out1_valid, out1_data);
    end
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    n_checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL indep_drain: got %b/%b expected 0/0", out0_valid, out1_valid);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    out0_ready = 1'b1;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = $urandom;
      tick();
      n_checks++;
      if (out0_valid !== 1'b1 || mq0.size() != 1 || out0_data !== mq0[0]) begin
        n_fail++;
        $display("FAIL wrap_word[%0d]: got %b/%h expected 1/%h", i, out0_valid, out0_data,
                 in_data);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (cnt0 !== 4'd1 || out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_cnt: cnt0 %0d valid %b expected 1/0", cnt0, out0_valid);
    end
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'h1234_5678;
    tick();
    in_sel  = 1'b1;
    in_data = 32'h9ABC_DEF0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_full: got %b/%b expected 1/1", out0_valid, out1_valid);
    end
    rst        = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    rst        = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #1;
    n_checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== '0 || cnt1 !== '0 ||
        out0_data !== '0 || out1_data !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_clear: valid %b/%b cnt %0d/%0d data %h/%h rdy %b expected 0s, rdy 1",
               out0_valid, out1_valid, cnt0, cnt1, out0_data, out1_data, in_ready);
    end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(63) == 0);
      out0_ready = ($urandom_range(3) != 0);
      out1_ready = ($urandom_range(2) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(3) != 0);
        in_sel   = $urandom_range(1) != 0;
        in_data  = $urandom;
      end
      #1;
      n_checks++;
      if (in_ready !== model_in_ready()) begin
        n_fail++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, model_in_ready());
      end
      hold = in_valid && !model_in_ready() && !rst;
      tick();
      n_checks++;
      if (out0_valid !== (mq0.size() != 0) || out1_valid !== (mq1.size() != 0) ||
          (mq0.size() != 0 && out0_data !== mq0[0]) ||
          (mq1.size() != 0 && out1_data !== mq1[0])) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: out0 %b/%h out1 %b/%h expected %0d/%0d pending",
                 c, out0_valid, out0_data, out1_valid, out1_data, mq0.size(), mq1.size());
      end
      n_checks++;
      if (cnt0 !== CW'(mcnt0) || cnt1 !== CW'(mcnt1)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", c, cnt0, cnt1, mcnt0,
                 mcnt1);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    mcnt0      = 0;
    mcnt1      = 0;
    test_reset();
    test_stream();
    test_stall();
    test_independence();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
